operand_fetch_stage: RTL and testbench

Decode-to-execute operand stage that sits directly downstream of the register file's three read ports (Y1/Y2/Y3). It resolves data hazards against instructions in EX, MEM and WB using forwarding, detects load-use hazards and stalls fetch/decode, then captures operands and the control word into the ID/EX pipeline register. Branch flush and bubble insertion are handled here. A saturating stall counter supports performance debug.

---
 rtl/arm_pipe_pkg.sv | 20 ++
 rtl/operand_fwd_mux.sv | 85 ++++++++
 rtl/operand_fetch_stage.sv | 151 +++++++++++++++
 tb/tb_operand_fetch_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// ---------------------------------------------------------------------------
// arm_pipe_pkg
// Shared definitions for the decode-to-execute operand stage.
//   CTRL_W     : default width of the decoded control word carried to EX
//   REG_PC     : register number of the PC (R15), never forwarded or hazarded
//   fwd_sel_e  : operand source selected by the forwarding mux
// ---------------------------------------------------------------------------
package arm_pipe_pkg;

  localparam int unsigned CTRL_W = 24;
  localparam logic [3:0]  REG_PC = 4'hF;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_EX  = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// ---------------------------------------------------------------------------
// operand_fwd_mux
// Resolves one source operand against the instructions in EX, MEM and WB.
// Build option: OPERAND_FORWARD_EN
//   defined   : EX (non-load) > MEM > WB > register file forwarding; only a
//               load in EX producing this source raises the hazard flag.
//   undefined : operand always comes from the register file; any writer in
//               EX, MEM or WB producing this source raises the hazard flag.
// Ports:
//   idx_i, use_i          source register number / source is really read
//   ex_*_i, mem_*_i, wb_*_i  pipeline destination, write enable and data
//   rf_data_i             register-file read data for this source
//   operand_o             resolved operand
//   hazard_o              this source cannot be resolved this cycle
// ---------------------------------------------------------------------------
module operand_fwd_mux (
  input  logic [3:0]  idx_i,
  input  logic        use_i,
  input  logic        ex_wr_i,
  input  logic        ex_load_i,
  input  logic [3:0]  ex_dest_i,
  input  logic [31:0] ex_result_i,
  input  logic        mem_wr_i,
  input  logic [3:0]  mem_dest_i,
  input  logic [31:0] mem_result_i,
  input  logic        wb_wr_i,
  input  logic [3:0]  wb_dest_i,
  input  logic [31:0] wb_data_i,
  input  logic [31:0] rf_data_i,
  output logic [31:0] operand_o,
  output logic        hazard_o
);
  import arm_pipe_pkg::*;

  logic     tracked_s;
  logic     ex_load_hit_s;
  logic     ex_alu_hit_s;
  logic     mem_hit_s;
  logic     wb_hit_s;
  fwd_sel_e sel_s;

  // Unused sources and the PC never take part in dependency checks.
  assign tracked_s     = use_i && (idx_i != REG_PC);
  assign ex_load_hit_s = tracked_s && ex_wr_i && (ex_dest_i == idx_i) && ex_load_i;
  assign ex_alu_hit_s  = tracked_s && ex_wr_i && (ex_dest_i == idx_i) && !ex_load_i;
  assign mem_hit_s     = tracked_s && mem_wr_i && (mem_dest_i == idx_i);
  assign wb_hit_s      = tracked_s && wb_wr_i && (wb_dest_i == idx_i);

`ifdef OPERAND_FORWARD_EN
  // Youngest producer wins; a load in EX has no data yet, so it is skipped
  // here and reported as a hazard instead. WB must forward because the
  // register file reads before it writes.
  always_comb begin
    sel_s = FWD_RF;
    if (ex_alu_hit_s) begin
      sel_s = FWD_EX;
    end else if (mem_hit_s) begin
      sel_s = FWD_MEM;
    end else if (wb_hit_s) begin
      sel_s = FWD_WB;
    end else begin
      sel_s = FWD_RF;
    end
  end

  assign hazard_o = ex_load_hit_s;
`else
  // Without forwarding every in-flight producer must drain past WB.
  assign sel_s    = FWD_RF;
  assign hazard_o = ex_load_hit_s || ex_alu_hit_s || mem_hit_s || wb_hit_s;
`endif

  // Operand data select.
  always_comb begin
    operand_o = rf_data_i;
    case (sel_s)
      FWD_EX:  operand_o = ex_result_i;
      FWD_MEM: operand_o = mem_result_i;
      FWD_WB:  operand_o = wb_data_i;
      FWD_RF:  operand_o = rf_data_i;
      default: operand_o = rf_data_i;
    endcase
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// ---------------------------------------------------------------------------
// operand_fetch_stage
// Decode-to-execute operand stage: resolves rn/rm/rs against EX/MEM/WB,
// detects hazards, and loads the ID/EX pipeline register.
// Build option: OPERAND_FORWARD_EN (see operand_fwd_mux); undefined by default,
// in which case no forwarding is done and dependents stall until written back.
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   id_valid, id_ctrl     decode instruction valid / decoded control word
//   rn/rm/rs_idx, use_*   source register numbers and read flags
//   rf_y1/y2/y3           register-file read data for rn/rm/rs
//   ex_*, mem_*, wb_*     downstream destinations, write enables and data
//   flush                 kill the instruction entering EX
//   hazard_stall          combinational stall for IF/ID and the PC enable
//   ex_valid, ex_ctrl     registered EX valid / control word
//   ex_a, ex_b, ex_c      registered resolved operands (rn, rm, rs)
//   stall_count           registered saturating count of stall cycles
// ---------------------------------------------------------------------------
module operand_fetch_stage #(
  parameter int unsigned CTRL_W = arm_pipe_pkg::CTRL_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [3:0]        rn_idx,
  input  logic [3:0]        rm_idx,
  input  logic [3:0]        rs_idx,
  input  logic              use_rn,
  input  logic              use_rm,
  input  logic              use_rs,
  input  logic [31:0]       rf_y1,
  input  logic [31:0]       rf_y2,
  input  logic [31:0]       rf_y3,
  input  logic              ex_wr,
  input  logic              ex_load,
  input  logic [3:0]        ex_dest,
  input  logic [31:0]       ex_result,
  input  logic              mem_wr,
  input  logic [3:0]        mem_dest,
  input  logic [31:0]       mem_result,
  input  logic              wb_wr,
  input  logic [3:0]        wb_dest,
  input  logic [31:0]       wb_data,
  input  logic              flush,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_a,
  output logic [31:0]       ex_b,
  output logic [31:0]       ex_c,
  output logic [CNT_W-1:0]  stall_count
);

  logic [31:0]       op_a_s, op_b_s, op_c_s;
  logic              haz_a_s, haz_b_s, haz_c_s;
  logic              hazard_stall_s;

  logic              ex_valid_q, ex_valid_d;
  logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
  logic [31:0]       ex_a_q, ex_a_d;
  logic [31:0]       ex_b_q, ex_b_d;
  logic [31:0]       ex_c_q, ex_c_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  operand_fwd_mux u_fwd_rn (
    .idx_i(rn_idx), .use_i(use_rn),
    .ex_wr_i(ex_wr), .ex_load_i(ex_load), .ex_dest_i(ex_dest), .ex_result_i(ex_result),
    .mem_wr_i(mem_wr), .mem_dest_i(mem_dest), .mem_result_i(mem_result),
    .wb_wr_i(wb_wr), .wb_dest_i(wb_dest), .wb_data_i(wb_data),
    .rf_data_i(rf_y1), .operand_o(op_a_s), .hazard_o(haz_a_s)
  );

  operand_fwd_mux u_fwd_rm (
    .idx_i(rm_idx), .use_i(use_rm),
    .ex_wr_i(ex_wr), .ex_load_i(ex_load), .ex_dest_i(ex_dest), .ex_result_i(ex_result),
    .mem_wr_i(mem_wr), .mem_dest_i(mem_dest), .mem_result_i(mem_result),
    .wb_wr_i(wb_wr), .wb_dest_i(wb_dest), .wb_data_i(wb_data),
    .rf_data_i(rf_y2), .operand_o(op_b_s), .hazard_o(haz_b_s)
  );

  operand_fwd_mux u_fwd_rs (
    .idx_i(rs_idx), .use_i(use_rs),
    .ex_wr_i(ex_wr), .ex_load_i(ex_load), .ex_dest_i(ex_dest), .ex_result_i(ex_result),
    .mem_wr_i(mem_wr), .mem_dest_i(mem_dest), .mem_result_i(mem_result),
    .wb_wr_i(wb_wr), .wb_dest_i(wb_dest), .wb_data_i(wb_data),
    .rf_data_i(rf_y3), .operand_o(op_c_s), .hazard_o(haz_c_s)
  );

  // Must stay combinational: it gates the PC enable in the same cycle.
  assign hazard_stall_s = id_valid && (haz_a_s || haz_b_s || haz_c_s);
  assign hazard_stall   = hazard_stall_s;

  // ID/EX capture: flush, stall or an empty decode slot all insert a bubble.
  // Operands hold on a bubble; only valid and control are cleared.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_ctrl_d  = ex_ctrl_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_c_d     = ex_c_q;
    if (flush || hazard_stall_s || !id_valid) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = {CTRL_W{1'b0}};
    end else begin
      ex_valid_d = 1'b1;
      ex_ctrl_d  = id_ctrl;
      ex_a_d     = op_a_s;
      ex_b_d     = op_b_s;
      ex_c_d     = op_c_s;
    end
  end

  // Stall counter next state, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard_stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Pipeline register and counter state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= {CTRL_W{1'b0}};
      ex_a_q      <= 32'h0000_0000;
      ex_b_q      <= 32'h0000_0000;
      ex_c_q      <= 32'h0000_0000;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      ex_c_q      <= ex_c_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign ex_a        = ex_a_q;
  assign ex_b        = ex_b_q;
  assign ex_c        = ex_c_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage. Expected values come from a
// rule-level reference model; OPERAND_FORWARD_EN selects the model variant.
module tb_operand_fetch_stage;

  localparam int CTRL_W = 24;
  localparam int CNT_W  = 16;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              id_valid;
  logic [CTRL_W-1:0] id_ctrl;
  logic [3:0]        rn_idx, rm_idx, rs_idx;
  logic              use_rn, use_rm, use_rs;
  logic [31:0]       rf_y1, rf_y2, rf_y3;
  logic              ex_wr, ex_load;
  logic [3:0]        ex_dest;
  logic [31:0]       ex_result;
  logic              mem_wr;
  logic [3:0]        mem_dest;
  logic [31:0]       mem_result;
  logic              wb_wr;
  logic [3:0]        wb_dest;
  logic [31:0]       wb_data;
  logic              flush;
  logic              hazard_stall;
  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [31:0]       ex_a, ex_b, ex_c;
  logic [CNT_W-1:0]  stall_count;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [31:0]       m_a, m_b, m_c;
  logic [CNT_W-1:0]  m_cnt;

  always #5 clock = ~clock;

  operand_fetch_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .rn_idx(rn_idx), .rm_idx(rm_idx), .rs_idx(rs_idx),
    .use_rn(use_rn), .use_rm(use_rm), .use_rs(use_rs),
    .rf_y1(rf_y1), .rf_y2(rf_y2), .rf_y3(rf_y3),
    .ex_wr(ex_wr), .ex_load(ex_load), .ex_dest(ex_dest), .ex_result(ex_result),
    .mem_wr(mem_wr), .mem_dest(mem_dest), .mem_result(mem_result),
    .wb_wr(wb_wr), .wb_dest(wb_dest), .wb_data(wb_data),
    .flush(flush), .hazard_stall(hazard_stall), .ex_valid(ex_valid),
    .ex_ctrl(ex_ctrl), .ex_a(ex_a), .ex_b(ex_b), .ex_c(ex_c),
    .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value a source should see, from the forwarding rules.
  function automatic logic [31:0] src_val(input logic [3:0] idx, input logic u,
                                          input logic [31:0] rf);
`ifdef OPERAND_FORWARD_EN
    if (!u || idx == 4'hF) return rf;
    if (ex_wr && !ex_load && ex_dest == idx) return ex_result;
    if (mem_wr && mem_dest == idx) return mem_result;
    if (wb_wr && wb_dest == idx) return wb_data;
`endif
    return rf;
  endfunction

  // Whether a source blocks issue, from the hazard rules.
  function automatic logic src_haz(input logic [3:0] idx, input logic u);
    if (!u || idx == 4'hF) return 1'b0;
`ifdef OPERAND_FORWARD_EN
    return ex_wr && ex_load && ex_dest == idx;
`else
    return (ex_wr && ex_dest == idx) || (mem_wr && mem_dest == idx) ||
           (wb_wr && wb_dest == idx);
`endif
  endfunction

  task automatic drive_idle();
    id_valid = 1'b0; id_ctrl = '0;
    rn_idx = 4'd0; rm_idx = 4'd0; rs_idx = 4'd0;
    use_rn = 1'b0; use_rm = 1'b0; use_rs = 1'b0;
    rf_y1 = 32'h0; rf_y2 = 32'h0; rf_y3 = 32'h0;
    ex_wr = 1'b0; ex_load = 1'b0; ex_dest = 4'd0; ex_result = 32'h0;
    mem_wr = 1'b0; mem_dest = 4'd0; mem_result = 32'h0;
    wb_wr = 1'b0; wb_dest = 4'd0; wb_data = 32'h0;
    flush = 1'b0;
  endtask

  // One clock: check the combinational stall, advance the model, check registers.
  task automatic cycle();
    logic eh;
    #1;
    eh = id_valid && (src_haz(rn_idx, use_rn) || src_haz(rm_idx, use_rm) ||
                      src_haz(rs_idx, use_rs));
    chk("hazard_stall", 64'(hazard_stall), 64'(eh));
    if (flush || eh || !id_valid) begin
      m_valid = 1'b0;
      m_ctrl  = '0;
    end else begin
      m_valid = 1'b1;
      m_ctrl  = id_ctrl;
      m_a     = src_val(rn_idx, use_rn, rf_y1);
      m_b     = src_val(rm_idx, use_rm, rf_y2);
      m_c     = src_val(rs_idx, use_rs, rf_y3);
    end
    if (eh && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    @(posedge clock);
    #1;
    chk("ex_valid", 64'(ex_valid), 64'(m_valid));
    chk("ex_ctrl", 64'(ex_ctrl), 64'(m_ctrl));
    chk("ex_a", 64'(ex_a), 64'(m_a));
    chk("ex_b", 64'(ex_b), 64'(m_b));
    chk("ex_c", 64'(ex_c), 64'(m_c));
    chk("stall_count", 64'(stall_count), 64'(m_cnt));
  endtask

  function automatic logic [3:0] rand_reg();
    if ($urandom_range(0, 4) == 0) return 4'hF;
    return 4'($urandom_range(0, 3));
  endfunction

  initial begin
    reset_n = 1'b0;
    drive_idle();
    m_valid = 1'b0; m_ctrl = '0; m_a = 32'h0; m_b = 32'h0; m_c = 32'h0; m_cnt = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 64'(ex_valid), 64'd0);
    chk("rst_ctrl", 64'(ex_ctrl), 64'd0);
    chk("rst_a", 64'(ex_a), 64'd0);
    chk("rst_cnt", 64'(stall_count), 64'd0);
    reset_n = 1'b1;

    // independent operand
    id_valid = 1'b1; id_ctrl = 24'h123456;
    rn_idx = 4'd2; use_rn = 1'b1; rf_y1 = 32'h1111_1111;
    cycle();
    chk("indep_a", 64'(ex_a), 64'h1111_1111);
    chk("indep_valid", 64'(ex_valid), 64'd1);

    // EX versus MEM priority
    rn_idx = 4'd3; rf_y1 = 32'h3333_3333; id_ctrl = 24'h00A5A5;
    ex_wr = 1'b1; ex_dest = 4'd3; ex_result = 32'hAAAA_0000;
    mem_wr = 1'b1; mem_dest = 4'd3; mem_result = 32'hBBBB_0000;
    cycle();
`ifdef OPERAND_FORWARD_EN
    chk("ex_over_mem", 64'(ex_a), 64'hAAAA_0000);
`else
    chk("nofwd_ex_stall", 64'(ex_valid), 64'd0);
`endif

    // WB same-cycle write
    drive_idle();
    id_valid = 1'b1; id_ctrl = 24'h000777;
    rm_idx = 4'd5; use_rm = 1'b1; rf_y2 = 32'h0;
    wb_wr = 1'b1; wb_dest = 4'd5; wb_data = 32'h5050_5050;
    cycle();
`ifdef OPERAND_FORWARD_EN
    chk("wb_fwd", 64'(ex_b), 64'h5050_5050);
`else
    chk("nofwd_wb_stall", 64'(ex_valid), 64'd0);
`endif

    // load-use: stall, then load data arrives from MEM
    drive_idle();
    id_valid = 1'b1; id_ctrl = 24'h0000C4;
    rn_idx = 4'd4; use_rn = 1'b1; rf_y1 = 32'h4444_4444;
    ex_wr = 1'b1; ex_load = 1'b1; ex_dest = 4'd4; ex_result = 32'hDEAD_0000;
    cycle();
    chk("lu_bubble", 64'(ex_valid), 64'd0);
    ex_wr = 1'b0; ex_load = 1'b0;
    mem_wr = 1'b1; mem_dest = 4'd4; mem_result = 32'hC0FF_EE00;
    cycle();
`ifdef OPERAND_FORWARD_EN
    chk("lu_mem_fwd", 64'(ex_a), 64'hC0FF_EE00);
`else
    chk("nofwd_mem_stall", 64'(ex_valid), 64'd0);
`endif
    mem_wr = 1'b0; wb_wr = 1'b1; wb_dest = 4'd4; wb_data = 32'hC0FF_EE00;
    cycle();
    wb_wr = 1'b0;
    cycle();
    chk("lu_drained", 64'(ex_a), 64'h4444_4444);

    // R15 is never forwarded nor hazarded
    rn_idx = 4'hF; rf_y1 = 32'hF0F0_F0F0;
    ex_wr = 1'b1; ex_load = 1'b1; ex_dest = 4'hF; ex_result = 32'h1234_5678;
    cycle();
    chk("r15_a", 64'(ex_a), 64'hF0F0_F0F0);
    chk("r15_valid", 64'(ex_valid), 64'd1);

    // flush together with a load-use hazard
    rn_idx = 4'd4; ex_dest = 4'd4; flush = 1'b1; id_ctrl = 24'hFFFFFF;
    cycle();
    chk("flush_valid", 64'(ex_valid), 64'd0);
    chk("flush_ctrl", 64'(ex_ctrl), 64'd0);
    flush = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 7) != 0);
      flush    = ($urandom_range(0, 9) == 0);
      id_ctrl  = 24'($urandom);
      rn_idx = rand_reg(); rm_idx = rand_reg(); rs_idx = rand_reg();
      use_rn = 1'($urandom); use_rm = 1'($urandom); use_rs = 1'($urandom);
      rf_y1 = $urandom; rf_y2 = $urandom; rf_y3 = $urandom;
      ex_wr = 1'($urandom); ex_load = ($urandom_range(0, 3) == 0);
      ex_dest = rand_reg(); ex_result = $urandom;
      mem_wr = 1'($urandom); mem_dest = rand_reg(); mem_result = $urandom;
      wb_wr = 1'($urandom); wb_dest = rand_reg(); wb_data = $urandom;
      cycle();
    end

    // saturation: hold a load-use hazard for 2^CNT_W+3 cycles
    drive_idle();
    id_valid = 1'b1; id_ctrl = 24'h0BEEF0;
    rn_idx = 4'd1; use_rn = 1'b1; rf_y1 = 32'h0101_0101;
    ex_wr = 1'b1; ex_load = 1'b1; ex_dest = 4'd1;
    repeat ((1 << CNT_W) + 3) @(posedge clock);
    #1;
    m_cnt = 16'hFFFF; m_valid = 1'b0; m_ctrl = '0;
    chk("sat_cnt", 64'(stall_count), 64'(m_cnt));
    chk("sat_valid", 64'(ex_valid), 64'(m_valid));
    chk("sat_stall", 64'(hazard_stall), 64'd1);

    // asynchronous reset in the middle of the stall
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(ex_valid), 64'd0);
    chk("arst_ctrl", 64'(ex_ctrl), 64'd0);
    chk("arst_a", 64'(ex_a), 64'd0);
    chk("arst_b", 64'(ex_b), 64'd0);
    chk("arst_c", 64'(ex_c), 64'd0);
    chk("arst_cnt", 64'(stall_count), 64'd0);
    chk("arst_stall_comb", 64'(hazard_stall), 64'd1);
    m_valid = 1'b0; m_ctrl = '0; m_a = 32'h0; m_b = 32'h0; m_c = 32'h0; m_cnt = '0;
    drive_idle();
    #2;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // one stall then a clean issue after reset
    id_valid = 1'b1; id_ctrl = 24'h00D00D;
    rs_idx = 4'd6; use_rs = 1'b1; rf_y3 = 32'h6666_6666;
    ex_wr = 1'b1; ex_load = 1'b1; ex_dest = 4'd6;
    cycle();
    ex_wr = 1'b0; ex_load = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
